lot_occupancy_counter: RTL and testbench
========================================

Name: lot_occupancy_counter

Overview:
Downstream consumer of the parking-lot entry and exit sensor FSMs. It takes their single-cycle car-passed outputs and tracks how many cars are in the lot. It derives the full, empty and free-space indications, and latches sticky overflow/underflow errors when sensor events contradict the count. Its outputs feed the lot display and the entry gate controller.

Parameters:
CAPACITY, 8, number of spaces in the lot; legal range 1..(2^CW - 1)
CW, 4, width of count and free outputs; must satisfy 2^CW > CAPACITY

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
car_in  input  1  car-entered indication from the entry sensor FSM; nominally a 1-cycle pulse
car_out  input  1  car-exited indication from the exit sensor FSM (its y output); nominally a 1-cycle pulse
clr_err  input  1  clears the sticky error flags
count  output  CW  cars currently in lot, registered
free  output  CW  CAPACITY - count, combinational from count
full  output  1  count == CAPACITY
empty  output  1  count == 0
overflow_err  output  1  sticky; an entry was seen while full
underflow_err  output  1  sticky; an exit was seen while empty

Behaviour:
- Reset (reset=1 at a clk edge) clears the following:
  - count=0, so free=CAPACITY, empty=1, full=0.
  - overflow_err=0, underflow_err=0.
  - Both input-history registers are set to 1.
- Reset dominates every other input on that edge.
- Edge detection: history registers in_q/out_q capture car_in/car_out every cycle.
  - in_evt = car_in & ~in_q; out_evt = car_out & ~out_q.
  - An input held high for N cycles counts once.
  - An input already high when reset releases is not counted until it falls and rises again.
- Latency: count changes on the same clk edge that first samples car_in/car_out high, i.e. it is visible 1 cycle after the pulse is presented. full/empty/free follow count with no extra delay.
- Count update per edge (reset=0):
  - in_evt only, count<CAPACITY: count+1.
  - in_evt only, count==CAPACITY: count holds; overflow_err<=1.
  - out_evt only, count>0: count-1.
  - out_evt only, count==0: count holds; underflow_err<=1.
  - in_evt and out_evt together: count holds at any value, including 0 and CAPACITY; no error is set.
  - Neither: count holds.
- count never exceeds CAPACITY and never wraps below 0.
- Error flags:
  - Set only as listed above, then held until cleared.
  - clr_err=1 clears both flags on that edge.
  - If a new error condition occurs on the same edge as clr_err, the set wins and that flag reads 1 afterwards. The other flag is still cleared.
  - Errors do not block counting.
- Mid-operation reset: count and flags return to reset values on the next edge regardless of in-flight events. An event pulse coincident with reset is discarded.
- No combinational path from car_in/car_out to any output.

Test Plan:
1. Reset, then one 1-cycle car_in pulse -> count 0->1 one cycle later; empty 1->0; free 8->7.
2. car_in held high 5 cycles -> count increments exactly once. Release and pulse again -> count +1 more.
3. Eight car_in pulses from reset -> count=8, full=1, free=0. A ninth pulse -> count stays 8 and overflow_err=1. Pulse clr_err -> overflow_err=0 and count still 8.
4. From count=0, car_out pulse -> count stays 0 and underflow_err=1. Then car_in and car_out pulsed in the same cycle at count=0 and again at count=8 -> count unchanged each time, no new error.
5. At count=8 with overflow_err=1, assert clr_err together with a new car_in pulse -> overflow_err remains 1 and count stays 8. Next cycle clr_err alone -> overflow_err=0.
6. car_in held high across reset release -> count stays 0. At count=5, assert reset for 1 cycle together with a car_out pulse -> count=0, errors=0, and no decrement is applied.

Source files
------------

// File: rtl/lot_occupancy_counter_if.sv
// Sensor-event and occupancy-status bundle between the entry/exit sensor FSMs,
// the occupancy counter, and its consumers (display, entry gate controller).
interface lot_occupancy_counter_if #(
  parameter int CW = 4
);
  logic          car_in;
  logic          car_out;
  logic          clr_err;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          full;
  logic          empty;
  logic          overflow_err;
  logic          underflow_err;

  // master drives sensor events and error clear; slave is the counter itself
  modport master (
    output car_in, car_out, clr_err,
    input  count, free, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  car_in, car_out, clr_err,
    output count, free, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/lot_occupancy_counter.sv
// Parking-lot occupancy counter: rising-edge detects car_in/car_out, saturates at
// 0 and CAPACITY, and latches sticky overflow/underflow errors.
module lot_occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int CW       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  lot_occupancy_counter_if.slave  bus
);

  localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic          in_q_r;
  logic          out_q_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] free_r;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;
  logic          unf_r;

  logic          in_evt_s;
  logic          out_evt_s;
  logic          ovf_set_s;
  logic          unf_set_s;
  logic [CW-1:0] count_nxt_s;
  logic          ovf_nxt_s;
  logic          unf_nxt_s;

  // Next-count and error-set decode from detected sensor edges
  always_comb begin
    in_evt_s    = bus.car_in  & ~in_q_r;
    out_evt_s   = bus.car_out & ~out_q_r;
    count_nxt_s = count_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    case ({in_evt_s, out_evt_s})
      2'b10: begin
        if (count_r == CAP_C) begin
          ovf_set_s = 1'b1;
        end else begin
          count_nxt_s = count_r + ONE_C;
        end
      end
      2'b01: begin
        if (count_r == ZERO_C) begin
          unf_set_s = 1'b1;
        end else begin
          count_nxt_s = count_r - ONE_C;
        end
      end
      // simultaneous entry and exit cancel; nothing pending holds
      default: begin
        count_nxt_s = count_r;
      end
    endcase
    // a fresh error on the clearing edge must survive the clear
    ovf_nxt_s = ovf_set_s | (ovf_r & ~bus.clr_err);
    unf_nxt_s = unf_set_s | (unf_r & ~bus.clr_err);
  end

  // State, edge history and derived status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q_r  <= 1'b1;
      out_q_r <= 1'b1;
      count_r <= ZERO_C;
      free_r  <= CAP_C;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      in_q_r  <= bus.car_in;
      out_q_r <= bus.car_out;
      count_r <= count_nxt_s;
      free_r  <= CAP_C - count_nxt_s;
      full_r  <= (count_nxt_s == CAP_C);
      empty_r <= (count_nxt_s == ZERO_C);
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  assign bus.count         = count_r;
  assign bus.free          = free_r;
  assign bus.full          = full_r;
  assign bus.empty         = empty_r;
  assign bus.overflow_err  = ovf_r;
  assign bus.underflow_err = unf_r;

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Table-driven and randomized checks of lot_occupancy_counter against the
// occupancy rules, using an arithmetic reference model for the random phase.
module tb_lot_occupancy_counter;

  localparam int CAP = 8;
  localparam int CW  = 4;

  logic clk;
  logic reset;

  lot_occupancy_counter_if #(.CW(CW)) bus ();

  lot_occupancy_counter #(.CAPACITY(CAP), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic ci;
    logic co;
    logic clr;
    int   cnt;
    logic ov;
    logic un;
  } vec_t;

  vec_t  tbl[$];
  int    errors = 0;
  int    checks = 0;
  string tag;

  // reference model state
  int    m_count;
  bit    m_ov, m_un, m_inq, m_outq;

  function automatic void add(input logic r, ci, co, clr, input int cnt, input logic ov, un);
    vec_t v;
    v.r = r; v.ci = ci; v.co = co; v.clr = clr; v.cnt = cnt; v.ov = ov; v.un = un;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic check_all(input int cnt, input bit ov, input bit un);
    check("count", int'(bus.count), cnt);
    check("free", int'(bus.free), CAP - cnt);
    check("full", int'(bus.full), (cnt == CAP) ? 1 : 0);
    check("empty", int'(bus.empty), (cnt == 0) ? 1 : 0);
    check("overflow_err", int'(bus.overflow_err), int'(ov));
    check("underflow_err", int'(bus.underflow_err), int'(un));
  endtask

  task automatic drive(input logic r, ci, co, clr);
    reset       = r;
    bus.car_in  = ci;
    bus.car_out = co;
    bus.clr_err = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge of the occupancy rules, in plain integer arithmetic
  task automatic model_step(input bit r, ci, co, clr);
    bit in_e, out_e, ov_set, un_set;
    in_e   = ci && !m_inq;
    out_e  = co && !m_outq;
    ov_set = 1'b0;
    un_set = 1'b0;
    if (r) begin
      m_count = 0; m_ov = 1'b0; m_un = 1'b0; m_inq = 1'b1; m_outq = 1'b1;
    end else begin
      if (in_e && !out_e) begin
        if (m_count >= CAP) ov_set = 1'b1;
        else m_count = m_count + 1;
      end else if (out_e && !in_e) begin
        if (m_count <= 0) un_set = 1'b1;
        else m_count = m_count - 1;
      end
      m_ov   = ov_set || (m_ov && !clr);
      m_un   = un_set || (m_un && !clr);
      m_inq  = ci;
      m_outq = co;
    end
  endtask

  initial begin
    // reset, plan 1, plan 2
    add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
    add(0,1,0,0, 1,0,0); add(0,0,0,0, 1,0,0);
    for (int k = 0; k < 5; k++) add(0,1,0,0, 2,0,0);
    add(0,0,0,0, 2,0,0); add(0,1,0,0, 3,0,0); add(0,0,0,0, 3,0,0);
    // plan 3: fill to capacity, overflow, clear
    add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
    for (int k = 1; k <= CAP; k++) begin
      add(0,1,0,0, k,0,0); add(0,0,0,0, k,0,0);
    end
    add(0,1,0,0, 8,1,0); add(0,0,0,0, 8,1,0); add(0,0,0,1, 8,0,0);
    // simultaneous entry/exit at capacity
    add(0,1,1,0, 8,0,0); add(0,0,0,0, 8,0,0);
    // plan 5: set on the clearing edge wins, then clear alone
    add(0,1,0,0, 8,1,0); add(0,0,0,0, 8,1,0);
    add(0,1,0,1, 8,1,0); add(0,0,0,1, 8,0,0);
    // plan 4: underflow at zero, simultaneous at zero
    add(1,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
    add(0,0,1,0, 0,0,1); add(0,0,0,0, 0,0,1);
    add(0,1,1,0, 0,0,1); add(0,0,0,0, 0,0,1);
    add(0,0,1,1, 0,0,1); add(0,0,0,1, 0,0,0);

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].ci, tbl[k].co, tbl[k].clr);
      tick();
      tag = $sformatf("row%0d", k);
      check_all(tbl[k].cnt, tbl[k].ov, tbl[k].un);
    end

    // plan 6: input held high across reset release is not counted
    tag = "held_across_reset";
    drive(1,1,0,0); tick(); check_all(0,0,0);
    for (int k = 0; k < 3; k++) begin
      drive(0,1,0,0); tick(); check_all(0,0,0);
    end
    drive(0,0,0,0); tick(); check_all(0,0,0);
    drive(0,1,0,0); tick(); check_all(1,0,0);
    drive(0,0,0,0); tick();
    for (int k = 2; k <= 5; k++) begin
      drive(0,1,0,0); tick();
      drive(0,0,0,0); tick();
    end
    tag = "count_at_5"; check_all(5,0,0);
    tag = "reset_with_exit";
    drive(1,0,1,0); tick(); check_all(0,0,0);
    drive(0,0,1,0); tick(); check_all(0,0,0);
    drive(0,0,0,0); tick(); check_all(0,0,0);

    // randomized phase with biased entry/exit probabilities
    drive(1,0,0,0); tick();
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++) begin
      int pin, pout;
      bit r, ci, co, clr;
      pin  = ((k / 60) % 2 == 0) ? 65 : 20;
      pout = ((k / 60) % 2 == 0) ? 20 : 65;
      r    = ($urandom_range(0, 99) < 2);
      ci   = ($urandom_range(0, 99) < pin);
      co   = ($urandom_range(0, 99) < pout);
      clr  = ($urandom_range(0, 99) < 8);
      drive(r, ci, co, clr);
      tick();
      model_step(r, ci, co, clr);
      tag = $sformatf("rand%0d", k);
      check_all(m_count, m_ov, m_un);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
